// File: rtl/alu_operand_loader.sv
// Input stage for the 4-bit board ALU: synchronises and debounces the load
// and clear buttons, then sequences operand A, operand B and the opcode
// into held registers, flagging out_valid once a complete entry is present.
module alu_operand_loader #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 24
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] sw_data,
   input  logic [2:0] sw_op,
   input  logic       btn_load,
   input  logic       btn_clear,
   output logic [3:0] a_out,
   output logic [3:0] b_out,
   output logic [2:0] op_out,
   output logic       out_valid,
   output logic [1:0] state_out
);

   localparam logic [1:0] S_A    = 2'd0;
   localparam logic [1:0] S_B    = 2'd1;
   localparam logic [1:0] S_OP   = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Button lanes: bit 0 is load, bit 1 is clear.
   localparam int unsigned BTN_LOAD  = 0;
   localparam int unsigned BTN_CLEAR = 1;

   logic [1:0]       s1_q;
   logic [1:0]       s2_q;
   logic [1:0]       deb_q;
   logic [1:0]       deb_d;
   logic [1:0]       deb_dly_q;
   logic [CNT_W-1:0] cnt_q [2];
   logic [CNT_W-1:0] cnt_d [2];
   logic [1:0]       press;

   logic [1:0]       state_q, state_d;
   logic [3:0]       a_q, a_d;
   logic [3:0]       b_q, b_d;
   logic [2:0]       op_q, op_d;
   logic             valid_q, valid_d;

   // Debounce: accept a new level only after it persists for DEBOUNCE_CYCLES edges.
   always_comb begin
      deb_d = deb_q;
      for (int unsigned i = 0; i < 2; i++) begin
         cnt_d[i] = '0;
         if (s2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               deb_d[i] = s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   // Two-flop synchronisers, debounced levels, counters and edge history.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q      <= '0;
         s2_q      <= '0;
         deb_q     <= '0;
         deb_dly_q <= '0;
         cnt_q[0]  <= '0;
         cnt_q[1]  <= '0;
      end else begin
         s1_q      <= {btn_clear, btn_load};
         s2_q      <= s1_q;
         deb_q     <= deb_d;
         deb_dly_q <= deb_q;
         cnt_q[0]  <= cnt_d[0];
         cnt_q[1]  <= cnt_d[1];
      end
   end

   // One-cycle pulse per accepted rising level; releases give no pulse.
   assign press = deb_q & ~deb_dly_q;

   // Entry sequencer: clear takes priority over a coincident load.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      valid_d = valid_q;
      if (press[BTN_CLEAR]) begin
         state_d = S_A;
         a_d     = '0;
         b_d     = '0;
         op_d    = '0;
         valid_d = 1'b0;
      end else if (press[BTN_LOAD]) begin
         case (state_q)
            S_A: begin
               a_d     = sw_data;
               state_d = S_B;
            end
            S_B: begin
               b_d     = sw_data;
               state_d = S_OP;
            end
            S_OP: begin
               op_d    = sw_op;
               valid_d = 1'b1;
               state_d = S_DONE;
            end
            default: begin
               a_d     = sw_data;
               valid_d = 1'b0;
               state_d = S_B;
            end
         endcase
      end
   end

   // Operand, opcode, valid and state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_A;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         valid_q <= valid_d;
      end
   end

   assign a_out     = a_q;
   assign b_out     = b_q;
   assign op_out    = op_q;
   assign out_valid = valid_q;
   assign state_out = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with the default debounce length.
module tb_alu_operand_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] sw_data;
   logic [2:0] sw_op;
   logic       btn_load;
   logic       btn_clear;
   logic [3:0] a_out;
   logic [3:0] b_out;
   logic [2:0] op_out;
   logic       out_valid;
   logic [1:0] state_out;

   int checks = 0;
   int errors = 0;

   alu_operand_loader #(.DEBOUNCE_CYCLES(4), .CNT_W(24)) dut (
      .clk       (clk),
      .rst       (rst),
      .sw_data   (sw_data),
      .sw_op     (sw_op),
      .btn_load  (btn_load),
      .btn_clear (btn_clear),
      .a_out     (a_out),
      .b_out     (b_out),
      .op_out    (op_out),
      .out_valid (out_valid),
      .state_out (state_out)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                            input logic [2:0] eop, input logic ev, input logic [1:0] es);
      check({tag, ".a"},     {4'h0, a_out},     {4'h0, ea});
      check({tag, ".b"},     {4'h0, b_out},     {4'h0, eb});
      check({tag, ".op"},    {5'h0, op_out},    {5'h0, eop});
      check({tag, ".valid"}, {7'h0, out_valid}, {7'h0, ev});
      check({tag, ".state"}, {6'h0, state_out}, {6'h0, es});
   endtask

   // Hold the load button, then release long enough for the release to debounce.
   task automatic press_load(input int hold);
      btn_load = 1'b1;
      tick(hold);
      btn_load = 1'b0;
      tick(8);
   endtask

   initial begin
      rst = 1'b1; sw_data = 4'h0; sw_op = 3'h0; btn_load = 1'b0; btn_clear = 1'b0;
      tick(2);
      check_all("reset", 4'h0, 4'h0, 3'h0, 1'b0, 2'd0);
      rst = 1'b0;
      tick(20);
      check_all("idle", 4'h0, 4'h0, 3'h0, 1'b0, 2'd0);

      // Exact latency: first high sample at edge 1, capture at edge 7.
      sw_data = 4'h3;
      btn_load = 1'b1;
      tick(6);
      check("lat.a_before", {4'h0, a_out}, 8'h00);
      check("lat.state_before", {6'h0, state_out}, 8'h00);
      tick(1);
      check_all("capA", 4'h3, 4'h0, 3'h0, 1'b0, 2'd1);
      tick(3);
      check("held.state", {6'h0, state_out}, 8'h01);
      btn_load = 1'b0;
      tick(8);
      check("held.state_rel", {6'h0, state_out}, 8'h01);

      sw_data = 4'hA;
      press_load(10);
      check_all("capB", 4'h3, 4'hA, 3'h0, 1'b0, 2'd2);
      sw_op = 3'b001;
      press_load(10);
      check_all("capOp", 4'h3, 4'hA, 3'h1, 1'b1, 2'd3);

      // Three-cycle glitch is one short of acceptance.
      sw_data = 4'hF;
      btn_load = 1'b1;
      tick(3);
      btn_load = 1'b0;
      tick(10);
      check_all("glitch", 4'h3, 4'hA, 3'h1, 1'b1, 2'd3);

      // Four-cycle press is the shortest accepted one; restarts the entry.
      sw_data = 4'h5;
      press_load(4);
      check_all("restart", 4'h5, 4'hA, 3'h1, 1'b0, 2'd1);

      // Load and clear accepted on the same edge: clear wins.
      sw_data = 4'h7;
      btn_load = 1'b1;
      btn_clear = 1'b1;
      tick(10);
      btn_load = 1'b0;
      btn_clear = 1'b0;
      tick(8);
      check_all("clrwin", 4'h0, 4'h0, 3'h0, 1'b0, 2'd0);

      // Clear alone after capturing A.
      sw_data = 4'h9;
      press_load(10);
      check_all("capA2", 4'h9, 4'h0, 3'h0, 1'b0, 2'd1);
      btn_clear = 1'b1;
      tick(10);
      btn_clear = 1'b0;
      tick(8);
      check_all("clear", 4'h0, 4'h0, 3'h0, 1'b0, 2'd0);

      // Reset in the middle of a load debounce: no late capture.
      sw_data = 4'h6;
      press_load(10);
      check_all("capA3", 4'h6, 4'h0, 3'h0, 1'b0, 2'd1);
      sw_data = 4'hC;
      btn_load = 1'b1;
      tick(4);
      rst = 1'b1;
      btn_load = 1'b0;
      tick(2);
      rst = 1'b0;
      check_all("midrst", 4'h0, 4'h0, 3'h0, 1'b0, 2'd0);
      tick(15);
      check_all("nolate", 4'h0, 4'h0, 3'h0, 1'b0, 2'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
